// File: rtl/cla_pkg.sv
// rtl/cla_pkg.sv - shared constants and legality check for the pipelined CLA adder
package cla_pkg;

  localparam logic OP_ADD    = 1'b0;
  localparam logic OP_SUB    = 1'b1;
  localparam int   GROUP_DEF = 4;

  // One level-2 unit must cover every level-1 group, so the group count may not exceed GROUP
  function automatic bit legal_width(input int width, input int group);
    return (group > 0) && (width >= group) && ((width % group) == 0) && ((width / group) <= group);
  endfunction

endpackage

// File: rtl/cla_pipe_adder_if.sv
// rtl/cla_pipe_adder_if.sv - operand/result handshake bundle for cla_pipe_adder
interface cla_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             grp_p;
  logic             grp_g;

  modport master (
    output in_valid, a, b, cin, op, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, grp_p, grp_g
  );

  modport slave (
    input  in_valid, a, b, cin, op, out_ready,
    output in_ready, out_valid, sum, cout, ovf, grp_p, grp_g
  );
endinterface

// File: rtl/cla_lookahead_unit.sv
// rtl/cla_lookahead_unit.sv - N-input carry-lookahead unit (74182 generalised), active-high
module cla_lookahead_unit #(
  parameter int N = 4
) (
  input  logic [N-1:0] p,
  input  logic [N-1:0] g,
  input  logic         c_in,
  output logic [N-1:0] c,      // c[i] = carry into position i, c[0] = c_in
  output logic         blk_p,
  output logic         blk_g
);
  logic term;
  logic acc;
  logic gterm;

  // Flat sum-of-products carries: each c[i] is c_in or any g[j] with all p above j propagating
  always_comb begin
    c    = '0;
    term = 1'b0;
    acc  = 1'b0;
    for (int i = 0; i < N; i++) begin
      acc = c_in;
      for (int j = 0; j < i; j++) acc = acc & p[j];
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int k = j + 1; k < i; k++) term = term & p[k];
        acc = acc | term;
      end
      c[i] = acc;
    end
  end

  // Block propagate/generate, independent of c_in
  always_comb begin
    blk_p = &p;
    blk_g = 1'b0;
    gterm = 1'b0;
    for (int j = 0; j < N; j++) begin
      gterm = g[j];
      for (int k = j + 1; k < N; k++) gterm = gterm & p[k];
      blk_g = blk_g | gterm;
    end
  end
endmodule

// File: rtl/cla_pipe_adder.sv
// rtl/cla_pipe_adder.sv - two-stage pipelined two-level CLA adder/subtractor with valid/ready
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = GROUP_DEF
) (
  input logic            clk,
  input logic            rst,
  cla_pipe_adder_if.slave bus
);
  localparam int NG = WIDTH / GROUP;

  if (!legal_width(WIDTH, GROUP)) begin : g_bad_width
    $error("cla_pipe_adder: illegal WIDTH/GROUP combination");
  end

  logic             s1_adv, s2_adv;
  logic             s1_v, s2_v;

  logic [WIDTH-1:0] b_eff, p0, g0, k0;
  logic             c0;
  logic [NG-1:0]    gp0, gg0;

  logic [WIDTH-1:0] s1_p, s1_k;
  logic [NG-1:0]    s1_gp, s1_gg;
  logic             s1_c0;

  logic [NG-1:0]    gc;
  logic             blk_p, blk_g;
  logic [WIDTH-1:0] carry;
  logic             run;
  logic [WIDTH-1:0] sum_n;
  logic             cout_n, ovf_n;

  logic [WIDTH-1:0] sum_q;
  logic             cout_q, ovf_q, grp_p_q, grp_g_q;

  // Only out_ready reaches in_ready combinationally
  assign s2_adv       = !s2_v || bus.out_ready;
  assign s1_adv       = !s1_v || s2_adv;
  assign bus.in_ready = s1_adv;

  // Subtraction is a + ~b + 1, so the forced carry-in replaces cin
  always_comb begin
    b_eff = (bus.op == OP_SUB) ? ~bus.b : bus.b;
    c0    = (bus.op == OP_SUB) ? 1'b1 : bus.cin;
    p0    = bus.a ^ b_eff;
    g0    = bus.a & b_eff;
  end

  // Level-1 units with carry-in 0 give group P/G plus the carries generated inside each group
  for (genvar j = 0; j < NG; j++) begin : g_lvl1
    cla_lookahead_unit #(.N(GROUP)) u_lvl1 (
      .p     (p0[j*GROUP +: GROUP]),
      .g     (g0[j*GROUP +: GROUP]),
      .c_in  (1'b0),
      .c     (k0[j*GROUP +: GROUP]),
      .blk_p (gp0[j]),
      .blk_g (gg0[j])
    );
  end

  // Stage 1 register: loads only when it advances with a valid beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v  <= 1'b0;
      s1_p  <= '0;
      s1_k  <= '0;
      s1_gp <= '0;
      s1_gg <= '0;
      s1_c0 <= 1'b0;
    end else if (s1_adv) begin
      s1_v <= bus.in_valid;
      if (bus.in_valid) begin
        s1_p  <= p0;
        s1_k  <= k0;
        s1_gp <= gp0;
        s1_gg <= gg0;
        s1_c0 <= c0;
      end
    end
  end

  cla_lookahead_unit #(.N(NG)) u_lvl2 (
    .p     (s1_gp),
    .g     (s1_gg),
    .c_in  (s1_c0),
    .c     (gc),
    .blk_p (blk_p),
    .blk_g (blk_g)
  );

  // In-group carry = locally generated carry, or group carry-in propagated through lower bits
  always_comb begin
    carry = '0;
    run   = 1'b0;
    for (int j = 0; j < NG; j++) begin
      run = gc[j];
      for (int i = 0; i < GROUP; i++) begin
        carry[j*GROUP + i] = s1_k[j*GROUP + i] | run;
        run = run & s1_p[j*GROUP + i];
      end
    end
    sum_n  = s1_p ^ carry;
    cout_n = blk_g | (blk_p & s1_c0);
    ovf_n  = carry[WIDTH-1] ^ cout_n;
  end

  // Stage 2 register: results held bit-stable while stalled or on bubbles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v    <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      grp_p_q <= 1'b0;
      grp_g_q <= 1'b0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        sum_q   <= sum_n;
        cout_q  <= cout_n;
        ovf_q   <= ovf_n;
        grp_p_q <= blk_p;
        grp_g_q <= blk_g;
      end
    end
  end

  assign bus.out_valid = s2_v;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.grp_p     = grp_p_q;
  assign bus.grp_g     = grp_g_q;
endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb/tb_cla_pipe_adder.sv - scoreboard bench for cla_pipe_adder at WIDTH=16 and WIDTH=8
module tb_cla_pipe_adder;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   n_out16;
  int   n_out8;
  bit   done;

  logic [19:0] q16[$];
  logic [19:0] q8[$];

  cla_pipe_adder_if #(.WIDTH(16)) if16 ();
  cla_pipe_adder_if #(.WIDTH(8))  if8 ();

  cla_pipe_adder #(.WIDTH(16), .GROUP(4)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));
  cla_pipe_adder #(.WIDTH(8),  .GROUP(4)) dut8  (.clk(clk), .rst(rst), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Behavioural reference: plain integer add on b_eff/c0, block G = carry-out with zero carry-in
  function automatic logic [19:0] model(input int w, input logic [15:0] a, input logic [15:0] b,
                                        input logic ci, input logic o);
    logic [16:0] mask, ae, be, s, s0;
    logic [15:0] sm;
    logic        co, ov, gp, gg;
    mask = (17'd1 << w) - 17'd1;
    ae   = {1'b0, a} & mask;
    be   = (o ? ~{1'b0, b} : {1'b0, b}) & mask;
    s    = ae + be + (o ? 17'd1 : {16'd0, ci});
    s0   = ae + be;
    co   = s[w];
    gg   = s0[w];
    sm   = s[15:0] & mask[15:0];
    gp   = ((ae ^ be) == mask);
    ov   = (ae[w-1] == be[w-1]) && (sm[w-1] != ae[w-1]);
    return {sm, co, ov, gp, gg};
  endfunction

  function automatic logic [31:0] obs16();
    return {12'h0, if16.sum, if16.cout, if16.ovf, if16.grp_p, if16.grp_g};
  endfunction

  function automatic logic [31:0] obs8();
    return {20'h0, if8.sum, if8.cout, if8.ovf, if8.grp_p, if8.grp_g};
  endfunction

  task automatic drive(input logic v, input logic [15:0] a16, input logic [15:0] b16,
                       input logic [7:0] a8, input logic [7:0] b8, input logic ci, input logic o);
    if16.in_valid = v; if16.a = a16; if16.b = b16; if16.cin = ci; if16.op = o;
    if8.in_valid  = v; if8.a  = a8;  if8.b  = b8;  if8.cin  = ci; if8.op  = o;
  endtask

  task automatic set_ordy(input logic r);
    if16.out_ready = r;
    if8.out_ready  = r;
  endtask

  // Scoreboard: push on accepted input beat, pop and compare on delivered result
  always @(negedge clk) begin
    if (!rst) begin
      if (if16.in_valid && if16.in_ready) q16.push_back(model(16, if16.a, if16.b, if16.cin, if16.op));
      if (if8.in_valid && if8.in_ready)
        q8.push_back(model(8, {8'h0, if8.a}, {8'h0, if8.b}, if8.cin, if8.op));
      if (if16.out_valid && if16.out_ready) begin
        n_out16++;
        if (q16.size() == 0) chk("out16_unexpected", 1, 0);
        else chk("res16", obs16(), {12'h0, q16.pop_front()});
      end
      if (if8.out_valid && if8.out_ready) begin
        n_out8++;
        if (q8.size() == 0) chk("out8_unexpected", 1, 0);
        else chk("res8", obs8(), {12'h0, q8.pop_front()});
      end
    end
  end

  task automatic check_reset_state(input string tag);
    chk({tag, "_ovalid16"}, if16.out_valid, 0);
    chk({tag, "_ovalid8"}, if8.out_valid, 0);
    chk({tag, "_outs16"}, obs16(), 0);
    chk({tag, "_outs8"}, obs8(), 0);
    chk({tag, "_irdy16"}, if16.in_ready, 1);
  endtask

  task automatic drain();
    int guard;
    set_ordy(1);
    guard = 0;
    while ((q16.size() != 0 || q8.size() != 0 || if16.out_valid) && guard < 50) begin
      @(negedge clk); #1;
      guard++;
    end
    chk("drain16", q16.size(), 0);
    chk("drain8", q8.size(), 0);
  endtask

  task automatic send(input int n, input bit rnd);
    int acc, guard;
    bit pend;
    logic v, ci, o;
    logic [15:0] a16, b16;
    logic [7:0] a8, b8;
    acc = 0; guard = 0; pend = 0;
    while (acc < n && guard < 40 * n + 100) begin
      @(posedge clk); #1;
      if (!pend) begin
        v   = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
        a16 = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
        b16 = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
        a8  = 8'($urandom);
        b8  = ($urandom_range(0, 7) == 0) ? ~a8 : 8'($urandom);
        ci  = 1'($urandom);
        o   = 1'($urandom);
        drive(v, a16, b16, a8, b8, ci, o);
        pend = v;
      end
      @(negedge clk);
      if (if16.in_valid && if16.in_ready) begin
        acc++;
        pend = 0;
      end
      guard++;
    end
    @(posedge clk); #1;
    drive(0, 16'h0, 16'h0, 8'h0, 8'h0, 1'b0, 1'b0);
    chk("send_count", acc, n);
  endtask

  task automatic directed(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic ci, input logic o, input logic [19:0] exp);
    set_ordy(1);
    @(posedge clk); #1;
    drive(1, a, b, a[7:0], b[7:0], ci, o);
    @(negedge clk);
    chk({tag, "_irdy"}, if16.in_ready, 1);
    @(posedge clk); #1;
    drive(0, 16'h0, 16'h0, 8'h0, 8'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk({tag, "_lat1"}, if16.out_valid, 0);
    @(negedge clk);
    chk({tag, "_lat2"}, if16.out_valid, 1);
    chk({tag, "_res"}, obs16(), {12'h0, exp});
  endtask

  logic        iv[12];
  logic        ov[12];
  logic [31:0] snap;
  int          base, guard;

  initial begin
    total = 0; bad = 0; n_out16 = 0; n_out8 = 0; done = 0;
    rst = 1'b1;
    drive(0, 16'h0, 16'h0, 8'h0, 8'h0, 1'b0, 1'b0);
    set_ordy(1);
    repeat (3) @(posedge clk);
    #1;
    q16.delete(); q8.delete();
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("reset");

    // Boundary arithmetic: {sum, cout, ovf, grp_p, grp_g}
    directed("add_ffff_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b1, 1'b0});
    directed("sub_8000_1",   16'h8000, 16'h0001, 1'b0, 1'b1, {16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b1});
    directed("sub_0000_1",   16'h0000, 16'h0001, 1'b1, 1'b1, {16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0});
    directed("add_7fff_1",   16'h7FFF, 16'h0001, 1'b0, 1'b0, {16'h8000, 1'b0, 1'b1, 1'b0, 1'b0});
    directed("add_ffff_1",   16'hFFFF, 16'h0001, 1'b0, 1'b0, {16'h0000, 1'b1, 1'b0, 1'b0, 1'b1});
    drain();

    // Alternating bubbles: out_valid must replay in_valid two cycles later
    set_ordy(1);
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      drive(((c % 2) == 0), 16'($urandom), 16'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      @(negedge clk);
      iv[c] = if16.in_valid;
      ov[c] = if16.out_valid;
    end
    @(posedge clk); #1;
    drive(0, 16'h0, 16'h0, 8'h0, 8'h0, 1'b0, 1'b0);
    for (int c = 0; c < 12; c++) chk("alt_ovalid", ov[c], (c >= 2) ? iv[c-2] : 1'b0);
    drain();

    // Stall for three cycles right after the first result is delivered
    set_ordy(1);
    base = n_out16;
    fork
      send(5, 1'b0);
      begin
        guard = 0;
        while (n_out16 == base && guard < 50) begin
          @(negedge clk); #1;
          guard++;
        end
        chk("stall_first_seen", (n_out16 > base), 1);
        @(posedge clk); #1;
        set_ordy(0);
        @(negedge clk);
        snap = obs16();
        chk("stall_irdy", if16.in_ready, 0);
        chk("stall_ovalid", if16.out_valid, 1);
        repeat (2) begin
          @(negedge clk);
          chk("stall_hold", obs16(), snap);
          chk("stall_irdy", if16.in_ready, 0);
        end
        @(posedge clk); #1;
        set_ordy(1);
      end
    join
    drain();
    chk("stall_count", n_out16 - base, 5);

    // Reset with two beats in flight
    set_ordy(0);
    @(posedge clk); #1;
    drive(1, 16'hFFFF, 16'h0000, 8'hFF, 8'h00, 1'b1, 1'b0);
    @(posedge clk); #1;
    drive(1, 16'h1234, 16'h4321, 8'h12, 8'h34, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(0, 16'h0, 16'h0, 8'h0, 8'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_ovalid", if16.out_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    q16.delete(); q8.delete();
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("midrst");
    set_ordy(1);
    repeat (4) begin
      @(negedge clk);
      chk("midrst_no_stale", if16.out_valid | if8.out_valid, 0);
    end

    // Random traffic with random backpressure
    base = n_out16;
    done = 0;
    fork
      begin
        send(10000, 1'b1);
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk); #1;
          set_ordy($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    chk("rand_count16", n_out16 - base, 10000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
